pattern_serializer: RTL and testbench



---
 rtl/pattern_serializer.sv | 115 +++++++++++
 tb/tb_pattern_serializer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_serializer.sv
// pattern_serializer: captures a WIDTH-bit word over valid/ready and shifts it out
// one bit per CLK_DIV cycles, with frame markers and a completed-frame counter.
//   clk, rst_n          clock, asynchronous active-low reset
//   pat_in, load_valid  parallel word and its valid
//   load_ready          high while idle
//   ser_out, ser_valid  serial bit and frame-bit qualifier
//   frame_start         pulse on the first cycle of bit 0
//   frame_done          pulse on the idle cycle after the last bit
//   busy                frame in progress
//   words_sent          completed frames, wraps at 16 bits
module pattern_serializer #(
    parameter int WIDTH     = 64,
    parameter int CLK_DIV   = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pat_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy,
    output logic [15:0]      words_sent
);
    localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d, shifted;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic ser_out_q, ser_out_d, ser_valid_q, ser_valid_d;
    logic frame_start_q, frame_start_d, frame_done_q, frame_done_d;
    logic [15:0] words_q, words_d;
    logic div_end, bit_end;

    function automatic logic out_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    assign div_end = div_cnt_q == DW'(CLK_DIV - 1);
    assign bit_end = bit_cnt_q == BW'(WIDTH - 1);
    assign shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        bit_cnt_d     = bit_cnt_q;
        div_cnt_d     = div_cnt_q;
        ser_out_d     = ser_out_q;
        ser_valid_d   = ser_valid_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        words_d       = words_q;
        if (state_q == IDLE) begin
            if (load_valid) begin
                state_d       = SHIFT;
                shreg_d       = pat_in;
                bit_cnt_d     = '0;
                div_cnt_d     = '0;
                ser_out_d     = out_bit(pat_in);
                ser_valid_d   = 1'b1;
                frame_start_d = 1'b1;
            end
        end else if (!div_end) begin
            div_cnt_d = div_cnt_q + 1'b1;
        end else if (bit_end) begin
            state_d      = IDLE;
            ser_out_d    = 1'b0;
            ser_valid_d  = 1'b0;
            frame_done_d = 1'b1;
            words_d      = words_q + 16'd1;
        end else begin
            shreg_d   = shifted;
            bit_cnt_d = bit_cnt_q + 1'b1;
            div_cnt_d = '0;
            ser_out_d = out_bit(shifted);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            div_cnt_q     <= '0;
            ser_out_q     <= 1'b0;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            words_q       <= '0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            div_cnt_q     <= div_cnt_d;
            ser_out_q     <= ser_out_d;
            ser_valid_q   <= ser_valid_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            words_q       <= words_d;
        end
    end

    assign load_ready  = state_q == IDLE;
    assign busy        = state_q == SHIFT;
    assign ser_out     = ser_out_q;
    assign ser_valid   = ser_valid_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign words_sent  = words_q;
endmodule

// File: tb/tb_pattern_serializer.sv
// tb_pattern_serializer: directed checks of pattern_serializer in three configurations.
module tb_pattern_serializer;
    logic clk = 1'b0;
    logic rst_n;
    logic [63:0] pat [3];
    logic lv [3];
    logic lr [3];
    logic so [3];
    logic sv [3];
    logic fs [3];
    logic fd [3];
    logic by [3];
    logic [15:0] ws [3];
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    pattern_serializer #(.WIDTH(64), .CLK_DIV(1), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .pat_in(pat[0]), .load_valid(lv[0]), .load_ready(lr[0]),
        .ser_out(so[0]), .ser_valid(sv[0]), .frame_start(fs[0]), .frame_done(fd[0]),
        .busy(by[0]), .words_sent(ws[0]));
    pattern_serializer #(.WIDTH(64), .CLK_DIV(4), .MSB_FIRST(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .pat_in(pat[1]), .load_valid(lv[1]), .load_ready(lr[1]),
        .ser_out(so[1]), .ser_valid(sv[1]), .frame_start(fs[1]), .frame_done(fd[1]),
        .busy(by[1]), .words_sent(ws[1]));
    pattern_serializer #(.WIDTH(64), .CLK_DIV(1), .MSB_FIRST(1'b0)) u2 (
        .clk(clk), .rst_n(rst_n), .pat_in(pat[2]), .load_valid(lv[2]), .load_ready(lr[2]),
        .ser_out(so[2]), .ser_valid(sv[2]), .frame_start(fs[2]), .frame_done(fd[2]),
        .busy(by[2]), .words_sent(ws[2]));

    task automatic test_reset();
        logic [21:0] got;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            lv[i] = 1'b0;
            pat[i] = '1;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            got = {lr[i], so[i], sv[i], fs[i], fd[i], by[i], ws[i]};
            compared++;
            if (got !== 22'h20_0000) begin
                mismatched++;
                $display("FAIL reset_state[%0d]: got %h want %h", i, got, 22'h20_0000);
            end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            got = {lr[i], so[i], sv[i], fs[i], fd[i], by[i], ws[i]};
            compared++;
            if (got !== 22'h20_0000) begin
                mismatched++;
                $display("FAIL idle_after_reset[%0d]: got %h want %h", i, got, 22'h20_0000);
            end
        end
    endtask

    task automatic test_msb_div1();
        logic [63:0] p;
        p = 64'hAAAA_AAAA_AAAA_AAAA;
        pat[0] = p;
        lv[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lv[0] = 1'b0;
        for (int k = 0; k < 64; k++) begin
            compared++;
            if ({sv[0], by[0], lr[0], fs[0], fd[0], so[0]} !== {1'b1, 1'b1, 1'b0, k == 0, 1'b0, p[63-k]}) begin
                mismatched++;
                $display("FAIL msb_div1 bit %0d: got v%b b%b r%b s%b d%b o%b want o%b", k, sv[0], by[0], lr[0], fs[0], fd[0], so[0], p[63-k]);
            end
            @(negedge clk);
        end
        compared++;
        if ({sv[0], by[0], lr[0], fs[0], fd[0], so[0], ws[0]} !== {6'b001010, 16'd1}) begin
            mismatched++;
            $display("FAIL msb_div1 done: got v%b b%b r%b s%b d%b o%b ws=%0d want d=1 ws=1", sv[0], by[0], lr[0], fs[0], fd[0], so[0], ws[0]);
        end
        @(negedge clk);
        compared++;
        if (fd[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL msb_div1 done_pulse: got %b want 0", fd[0]);
        end
    endtask

    task automatic test_div4();
        logic [63:0] p;
        p = 64'hAAAA_AAAA_AAAA_AAAA;
        pat[1] = p;
        lv[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lv[1] = 1'b0;
        for (int c = 0; c < 256; c++) begin
            compared++;
            if ({sv[1], by[1], lr[1], fs[1], fd[1], so[1]} !== {1'b1, 1'b1, 1'b0, c == 0, 1'b0, p[63-c/4]}) begin
                mismatched++;
                $display("FAIL div4 cycle %0d: got v%b s%b d%b o%b want o%b", c, sv[1], fs[1], fd[1], so[1], p[63-c/4]);
            end
            @(negedge clk);
        end
        compared++;
        if ({sv[1], lr[1], fd[1], so[1], ws[1]} !== {4'b0110, 16'd1}) begin
            mismatched++;
            $display("FAIL div4 done: got v%b r%b d%b o%b ws=%0d want d=1 ws=1", sv[1], lr[1], fd[1], so[1], ws[1]);
        end
    endtask

    task automatic test_lsb_first();
        logic [63:0] p;
        p = 64'h0000_0000_0000_0001;
        pat[2] = p;
        lv[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lv[2] = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (k == 10) pat[2] = '1;
            compared++;
            if ({sv[2], fs[2], fd[2], so[2]} !== {1'b1, k == 0, 1'b0, p[k]}) begin
                mismatched++;
                $display("FAIL lsb_first bit %0d: got v%b s%b d%b o%b want o%b", k, sv[2], fs[2], fd[2], so[2], p[k]);
            end
            @(negedge clk);
        end
        compared++;
        if ({sv[2], lr[2], fd[2], ws[2]} !== {3'b011, 16'd1}) begin
            mismatched++;
            $display("FAIL lsb_first done: got v%b r%b d%b ws=%0d want d=1 ws=1", sv[2], lr[2], fd[2], ws[2]);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] p;
        p = 64'hAAAA_AAAA_AAAA_AAAA;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pat[0] = p;
        lv[0] = 1'b1;
        @(negedge clk);
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 64; k++) begin
                compared++;
                if ({sv[0], lr[0], fs[0], fd[0], so[0]} !== {1'b1, 1'b0, k == 0, 1'b0, p[63-k]}) begin
                    mismatched++;
                    $display("FAIL b2b frame %0d bit %0d: got v%b r%b s%b d%b o%b", f, k, sv[0], lr[0], fs[0], fd[0], so[0]);
                end
                @(negedge clk);
            end
            compared++;
            if ({sv[0], lr[0], fd[0], ws[0]} !== {3'b011, 16'(f + 1)}) begin
                mismatched++;
                $display("FAIL b2b gap %0d: got v%b r%b d%b ws=%0d want ws=%0d", f, sv[0], lr[0], fd[0], ws[0], f + 1);
            end
            if (f == 2) lv[0] = 1'b0;
            @(negedge clk);
        end
        compared++;
        if ({sv[0], lr[0], fs[0]} !== 3'b010) begin
            mismatched++;
            $display("FAIL b2b idle: got v%b r%b s%b want 0 1 0", sv[0], lr[0], fs[0]);
        end
    endtask

    task automatic test_async_reset();
        logic [63:0] p;
        logic [21:0] got;
        p = 64'hAAAA_AAAA_AAAA_AAAA;
        pat[0] = p;
        lv[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lv[0] = 1'b0;
        repeat (20) @(negedge clk);
        compared++;
        if ({sv[0], so[0], ws[0]} !== {1'b1, p[43], 16'd3}) begin
            mismatched++;
            $display("FAIL areset bit20: got v%b o%b ws=%0d want v1 o%b ws=3", sv[0], so[0], ws[0], p[43]);
        end
        #2 rst_n = 1'b0;
        #1 got = {lr[0], so[0], sv[0], fs[0], fd[0], by[0], ws[0]};
        compared++;
        if (got !== 22'h20_0000) begin
            mismatched++;
            $display("FAIL areset immediate: got %h want %h", got, 22'h20_0000);
        end
        @(negedge clk);
        compared++;
        if ({fd[0], sv[0]} !== 2'b00) begin
            mismatched++;
            $display("FAIL areset held: got d%b v%b want 0 0", fd[0], sv[0]);
        end
        rst_n = 1'b1;
        @(negedge clk);
        p = 64'hC000_0000_0000_0003;
        pat[0] = p;
        lv[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lv[0] = 1'b0;
        for (int k = 0; k < 64; k++) begin
            compared++;
            if ({sv[0], fs[0], fd[0], so[0]} !== {1'b1, k == 0, 1'b0, p[63-k]}) begin
                mismatched++;
                $display("FAIL areset reload bit %0d: got v%b s%b d%b o%b want o%b", k, sv[0], fs[0], fd[0], so[0], p[63-k]);
            end
            @(negedge clk);
        end
        compared++;
        if ({fd[0], ws[0]} !== {1'b1, 16'd1}) begin
            mismatched++;
            $display("FAIL areset reload done: got d%b ws=%0d want d1 ws=1", fd[0], ws[0]);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force u0.words_q = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release u0.words_q;
        @(negedge clk);
        compared++;
        if (ws[0] !== 16'hFFFF) begin
            mismatched++;
            $display("FAIL wrap preload: got %h want ffff", ws[0]);
        end
        pat[0] = 64'h1234_5678_9ABC_DEF0;
        lv[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lv[0] = 1'b0;
        repeat (64) @(negedge clk);
        compared++;
        if ({fd[0], ws[0]} !== {1'b1, 16'h0000}) begin
            mismatched++;
            $display("FAIL wrap: got d%b ws=%h want d1 ws=0000", fd[0], ws[0]);
        end
    endtask

    initial begin
        test_reset();
        test_msb_div1();
        test_div4();
        test_lsb_first();
        test_back_to_back();
        test_async_reset();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
